// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// One access in flight at a time; ties alternate between the two requesters.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MEM_LAT) + 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              owner_reg, owner_next;   // 1 = data port owns the access
  logic              last_reg, last_next;     // 1 = data port was granted last
  logic              window;
  logic              grant_if, grant_d, issue, rvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      owner_reg <= 1'b0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    grant_if   = 1'b0;
    grant_d    = 1'b0;

    // The window also opens on the response cycle so accesses can run back-to-back.
    window = (state_reg == S_IDLE) || (cnt_reg == '0);
    rvalid = !rst && (state_reg == S_WAIT) && (cnt_reg == '0);

    if (!rst && window) begin
      if (if_req && d_req) begin
        grant_d  = !last_reg;
        grant_if = last_reg;
      end else begin
        grant_d  = d_req;
        grant_if = if_req;
      end
    end
    issue = grant_if || grant_d;

    if (issue) begin
      state_next = S_WAIT;
      cnt_next   = CNT_W'(MEM_LAT - 1);
      owner_next = grant_d;
      last_next  = grant_d;
    end else if (state_reg == S_WAIT) begin
      if (cnt_reg != '0) begin
        cnt_next = cnt_reg - CNT_W'(1);
      end else begin
        state_next = S_IDLE;
      end
    end
  end

  assign if_gnt    = grant_if;
  assign d_gnt     = grant_d;
  assign if_rvalid = rvalid && !owner_reg;
  assign d_rvalid  = rvalid && owner_reg;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

  assign mem_en    = issue;
  assign mem_we    = grant_d && d_we;
  assign mem_addr  = grant_d ? d_addr : (grant_if ? if_addr : '0);
  assign mem_wdata = grant_d ? d_wdata : '0;

  // Fetches read whole words; data accesses pass their own byte enables.
  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_be
      assign mem_be[gi] = grant_if || (grant_d && d_be[gi]);
    end
  endgenerate

endmodule
